alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 20 ++
 rtl/alu_sched.sv | 108 ++++++++++
 tb/tb_alu_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, latency table and FSM states
// shared by the ALU scheduler and its control logic
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam logic [2:0] LAT_ONE = 3'd1;
  localparam logic [2:0] LAT_MUL = 3'd2;
  localparam logic [2:0] LAT_DIV = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  // execution cycles the external ALU needs per opcode
  function automatic logic [2:0] lat(
    input logic [2:0] op
  );
    logic [2:0] l;
    l = LAT_ONE;
    unique case (op)
      OP_MUL:  l = LAT_MUL;
      OP_DIV:  l = LAT_DIV;
      default: l = LAT_ONE;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
// tie goes to the requester not granted last
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant; sole requester wins, ties alternate
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one external ALU between two
// requesters, multi-cycle ops, held response
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy
);

  state_t           state;
  logic [1:0]       cnt;
  logic             last_grant;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic [1:0]       grant;
  logic             idle;
  logic             acc0;
  logic             acc1;
  logic [2:0]       op_sel;
  logic [2:0]       lat_m1;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle       = (state == IDLE) && !rst;
  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign op_sel     = acc1 ? req1_op : req0_op;
  assign lat_m1     = lat(op_sel) - 3'd1;

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;

  // accept, count down the ALU latency, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last_grant <= 1'b1;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      id_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc0 || acc1) begin
            op_q       <= op_sel;
            a_q        <= acc1 ? req1_a : req0_a;
            b_q        <= acc1 ? req1_b : req0_b;
            id_q       <= acc1;
            last_grant <= acc1;
            cnt        <= lat_m1[1:0];
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            data_q <= alu_y;
            state  <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed table, corner sequences
// and randomized traffic against a cycle model
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .busy(busy)
  );

  // external combinational ALU; divide by zero gives all ones
  function automatic logic [7:0] alu_fn(
    input logic [2:0] op, input logic [7:0] a, input logic [7:0] b
  );
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return p[7:0];
      3'd3: return (b == 8'd0) ? 8'hFF : a / b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_op, alu_a, alu_b);

  function automatic int latency(input logic [2:0] op);
    if (op == 3'd2) return 2;
    if (op == 3'd3) return 4;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // cycle model: 0 = free, 1 = computing, 2 = holding result
  int         m_phase = 0;
  int         m_wait  = 0;
  int         m_last  = 1;
  int         m_id    = 0;
  logic [2:0] m_op    = 3'd0;
  logic [7:0] m_a     = 8'd0;
  logic [7:0] m_b     = 8'd0;
  logic [7:0] m_y     = 8'd0;

  // which requester the model would take this cycle (-1 none)
  function automatic int m_pick();
    if (rst || m_phase != 0) return -1;
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      int p;
      p = m_pick();
      chk("ready0", 32'(req0_ready), 32'(p == 0));
      chk("ready1", 32'(req1_ready), 32'(p == 1));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      if (m_phase == 2) begin
        chk("rsp_data", 32'(rsp_data), 32'(m_y));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
    end
  end

  always @(posedge clk) begin
    int p;
    p = m_pick();
    if (rst) begin
      m_phase = 0; m_last = 1;
      m_op = 3'd0; m_a = 8'd0; m_b = 8'd0;
    end else if (m_phase == 0) begin
      if (p >= 0) begin
        m_id    = p;
        m_op    = (p == 1) ? req1_op : req0_op;
        m_a     = (p == 1) ? req1_a : req0_a;
        m_b     = (p == 1) ? req1_b : req0_b;
        m_last  = p;
        m_y     = alu_fn(m_op, m_a, m_b);
        m_wait  = latency(m_op);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_wait--;
      if (m_wait == 0) m_phase = 2;
    end else if (rsp_ready) begin
      m_phase = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(
    input int id, input logic [2:0] op, input logic [7:0] a,
    input logic [7:0] b, output bit ok
  );
    ok = 0;
    if (id == 0) begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = (id == 0) ? (req0_valid && req0_ready)
                     : (req1_valid && req1_ready);
      tick();
    end
    req0_valid = 0;
    req1_valid = 0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  // cycles from the handshake cycle to first rsp_valid
  task automatic wait_rsp(output int c, output logic [7:0] d, output logic id);
    bit found;
    found = 0; c = 1; d = 8'd0; id = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1; d = rsp_data; id = rsp_id;
      end else begin
        c++;
      end
      tick();
    end
    if (!found) c = 0;
  endtask

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    int         cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit         ok;
    int         c;
    logic [7:0] d;
    logic       id;
    int         g[4];
    int         ng;
    int         nresp;

    vecs[0] = '{0, 3'd0, 8'd3,   8'd4,   8'd7,   2};
    vecs[1] = '{1, 3'd3, 8'd20,  8'd5,   8'd4,   5};
    vecs[2] = '{0, 3'd2, 8'd6,   8'd7,   8'd42,  3};
    vecs[3] = '{1, 3'd1, 8'd3,   8'd5,   8'hFE,  2};
    vecs[4] = '{0, 3'd4, 8'hF0,  8'h3C,  8'h30,  2};
    vecs[5] = '{1, 3'd5, 8'hF0,  8'h0F,  8'hFF,  2};
    vecs[6] = '{0, 3'd6, 8'hFF,  8'h0F,  8'hF0,  2};
    vecs[7] = '{1, 3'd7, 8'h55,  8'h00,  8'hAA,  2};
    vecs[8] = '{0, 3'd2, 8'd200, 8'd3,   8'h58,  3};

    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    tick();
    mon_en = 1;
    tick();
    rst = 0;
    tick();

    // contention straight after reset: 0,1,0,1
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2;
    req1_valid = 1; req1_op = 3'd0; req1_a = 8'd5; req1_b = 8'd6;
    ng = 0;
    for (int n = 0; n < 60 && ng < 4; n++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin g[ng] = 0; ng++; end
      else if (req1_valid && req1_ready) begin g[ng] = 1; ng++; end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) chk("rr_order", 32'(g[i]), 32'(i % 2));
    repeat (6) tick();

    // directed table
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, ok);
      wait_rsp(c, d, id);
      chk("tbl_latency", 32'(c), 32'(vecs[i].cyc));
      chk("tbl_data", 32'(d), 32'(vecs[i].y));
      chk("tbl_id", 32'(id), 32'(vecs[i].id));
      tick();
    end

    // backpressure on a MUL result
    rsp_ready = 0;
    start_op(0, 3'd2, 8'd6, 8'd7, ok);
    for (int n = 0; n < 10 && !rsp_valid; n++) tick();
    req0_valid = 1; req1_valid = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'd42);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    tick();
    tick();

    // reset during the second EXEC cycle of a DIV
    start_op(0, 3'd3, 8'd20, 8'd5, ok);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    nresp = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid) nresp++;
      tick();
    end
    chk("abort_no_rsp", 32'(nresp), 32'd0);
    start_op(0, 3'd0, 8'd3, 8'd4, ok);
    wait_rsp(c, d, id);
    chk("post_abort_lat", 32'(c), 32'd2);
    chk("post_abort_data", 32'(d), 32'd7);
    tick();

    // request pulsed while EXEC is ignored
    start_op(1, 3'd3, 8'd20, 8'd5, ok);
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'd9; req0_b = 8'd9;
    tick();
    req0_valid = 0;
    nresp = 0; d = 8'd0; id = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (rsp_valid) begin nresp++; d = rsp_data; id = rsp_id; end
      tick();
    end
    chk("wd_count", 32'(nresp), 32'd1);
    chk("wd_data", 32'(d), 32'd4);
    chk("wd_id", 32'(id), 32'd1);

    // randomized traffic checked by the cycle model
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(99) == 0);
      req0_valid = $urandom_range(1);
      req1_valid = $urandom_range(1);
      req0_op    = 3'($urandom_range(7));
      req1_op    = 3'($urandom_range(7));
      req0_a     = 8'($urandom);
      req0_b     = 8'($urandom);
      req1_a     = 8'($urandom);
      req1_b     = 8'($urandom);
      rsp_ready  = ($urandom_range(3) != 0);
      tick();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
